// File: rtl/color_blob_tracker.sv
// color_blob_tracker: multi-channel RGB threshold classifier with per-frame
// first-hit / bounding-box / pixel-count statistics and a registered report.

// One colour channel: hit classification, accumulators and report registers.
module color_blob_ch #(
  parameter int PIX_W   = 10,
  parameter int POS_W   = 13,
  parameter int CNT_W   = 20,
  parameter int MIN_PIX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pix,       // pixel belongs to an accumulating frame
  input  logic             i_clr,       // start accumulating from a clean slate
  input  logic             i_rpt,       // publish accumulators (including this pixel)
  input  logic             i_clr_post,  // clear after publishing (back-to-back frame)
  input  logic [PIX_W-1:0] i_R,
  input  logic [PIX_W-1:0] i_G,
  input  logic [PIX_W-1:0] i_B,
  input  logic [PIX_W-1:0] i_r_min,
  input  logic [PIX_W-1:0] i_g_max,
  input  logic [PIX_W-1:0] i_b_max,
  input  logic [POS_W-1:0] i_X_pos,
  input  logic [POS_W-1:0] i_Y_pos,
  output logic             o_detect,
  output logic [POS_W-1:0] o_first_x,
  output logic [POS_W-1:0] o_first_y,
  output logic [POS_W-1:0] o_x_min,
  output logic [POS_W-1:0] o_x_max,
  output logic [POS_W-1:0] o_y_min,
  output logic [POS_W-1:0] o_y_max,
  output logic [CNT_W-1:0] o_count,
  output logic             o_found
);

  localparam logic [31:0] MIN_U = MIN_PIX;

  logic             r_seen;
  logic [POS_W-1:0] r_first_x, r_first_y, r_x_min, r_x_max, r_y_min, r_y_max;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hit;
  logic             w_seen_b, w_seen_n;
  logic [POS_W-1:0] w_fx_b, w_fy_b, w_xmin_b, w_xmax_b, w_ymin_b, w_ymax_b;
  logic [POS_W-1:0] w_fx_n, w_fy_n, w_xmin_n, w_xmax_n, w_ymin_n, w_ymax_n;
  logic [CNT_W-1:0] w_cnt_b, w_cnt_n;

  assign w_hit = i_pix & (i_R > i_r_min) & (i_G < i_g_max) & (i_B < i_b_max);

  // Base = accumulators (or cleared values on frame entry); next = base + this hit.
  always_comb begin
    w_seen_b = r_seen;
    w_fx_b   = r_first_x;
    w_fy_b   = r_first_y;
    w_xmin_b = r_x_min;
    w_xmax_b = r_x_max;
    w_ymin_b = r_y_min;
    w_ymax_b = r_y_max;
    w_cnt_b  = r_cnt;
    if (i_clr) begin
      w_seen_b = 1'b0;
      w_fx_b   = '0;
      w_fy_b   = '0;
      w_xmin_b = '1;
      w_xmax_b = '0;
      w_ymin_b = '1;
      w_ymax_b = '0;
      w_cnt_b  = '0;
    end
    w_seen_n = w_seen_b;
    w_fx_n   = w_fx_b;
    w_fy_n   = w_fy_b;
    w_xmin_n = w_xmin_b;
    w_xmax_n = w_xmax_b;
    w_ymin_n = w_ymin_b;
    w_ymax_n = w_ymax_b;
    w_cnt_n  = w_cnt_b;
    if (w_hit) begin
      w_cnt_n = (&w_cnt_b) ? w_cnt_b : w_cnt_b + CNT_W'(1);
      if (i_X_pos < w_xmin_b) w_xmin_n = i_X_pos;
      if (i_X_pos > w_xmax_b) w_xmax_n = i_X_pos;
      if (i_Y_pos < w_ymin_b) w_ymin_n = i_Y_pos;
      if (i_Y_pos > w_ymax_b) w_ymax_n = i_Y_pos;
      if (!w_seen_b) begin
        w_seen_n = 1'b1;
        w_fx_n   = i_X_pos;
        w_fy_n   = i_Y_pos;
      end
    end
  end

  // Accumulators, first-hit pulse and report registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seen    <= 1'b0;
      r_first_x <= '0;
      r_first_y <= '0;
      r_x_min   <= '1;
      r_x_max   <= '0;
      r_y_min   <= '1;
      r_y_max   <= '0;
      r_cnt     <= '0;
      o_detect  <= 1'b0;
      o_first_x <= '0;
      o_first_y <= '0;
      o_x_min   <= '0;
      o_x_max   <= '0;
      o_y_min   <= '0;
      o_y_max   <= '0;
      o_count   <= '0;
      o_found   <= 1'b0;
    end else begin
      o_detect <= w_hit & ~w_seen_b;
      if (i_clr_post) begin
        r_seen    <= 1'b0;
        r_first_x <= '0;
        r_first_y <= '0;
        r_x_min   <= '1;
        r_x_max   <= '0;
        r_y_min   <= '1;
        r_y_max   <= '0;
        r_cnt     <= '0;
      end else begin
        r_seen    <= w_seen_n;
        r_first_x <= w_fx_n;
        r_first_y <= w_fy_n;
        r_x_min   <= w_xmin_n;
        r_x_max   <= w_xmax_n;
        r_y_min   <= w_ymin_n;
        r_y_max   <= w_ymax_n;
        r_cnt     <= w_cnt_n;
      end
      if (i_rpt) begin
        // A channel with no hits reports an all-zero box instead of the
        // all-ones/zero sentinels held in the accumulators.
        o_first_x <= w_seen_n ? w_fx_n   : '0;
        o_first_y <= w_seen_n ? w_fy_n   : '0;
        o_x_min   <= w_seen_n ? w_xmin_n : '0;
        o_x_max   <= w_seen_n ? w_xmax_n : '0;
        o_y_min   <= w_seen_n ? w_ymin_n : '0;
        o_y_max   <= w_seen_n ? w_ymax_n : '0;
        o_count   <= w_cnt_n;
        o_found   <= 32'(w_cnt_n) >= MIN_U;
      end
    end
  end

endmodule

module color_blob_tracker #(
  parameter int PIX_W   = 10,
  parameter int POS_W   = 13,
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 20,
  parameter int MIN_PIX = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [PIX_W-1:0]        i_R,
  input  logic [PIX_W-1:0]        i_G,
  input  logic [PIX_W-1:0]        i_B,
  input  logic [POS_W-1:0]        i_X_pos,
  input  logic [POS_W-1:0]        i_Y_pos,
  input  logic                    new_frame,
  input  logic                    end_frame,
  input  logic [NUM_CH*PIX_W-1:0] i_r_min,
  input  logic [NUM_CH*PIX_W-1:0] i_g_max,
  input  logic [NUM_CH*PIX_W-1:0] i_b_max,
  output logic [NUM_CH-1:0]       o_detect,
  output logic [NUM_CH*POS_W-1:0] o_first_x,
  output logic [NUM_CH*POS_W-1:0] o_first_y,
  output logic [NUM_CH*POS_W-1:0] o_x_min,
  output logic [NUM_CH*POS_W-1:0] o_x_max,
  output logic [NUM_CH*POS_W-1:0] o_y_min,
  output logic [NUM_CH*POS_W-1:0] o_y_max,
  output logic [NUM_CH*CNT_W-1:0] o_count,
  output logic [NUM_CH-1:0]       o_found,
  output logic                    o_frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPORT} state_t;

  state_t r_state, w_state_n;
  logic   r_pend;     // new_frame arrived together with end_frame
  logic   w_pend_n;
  logic   w_pix, w_clr, w_rpt, w_clr_post;

  // State register, pending restart flag and frame-done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pend       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pend       <= w_pend_n;
      o_frame_done <= w_rpt;
    end
  end

  // Next state and per-cycle accumulator controls.
  always_comb begin
    w_state_n  = r_state;
    w_pend_n   = 1'b0;
    w_rpt      = 1'b0;
    // new_frame opens (or restarts) a frame and its pixel counts there,
    // unless end_frame also fires in ACCUM: then the pixel closes this frame.
    w_pix      = i_valid & ((r_state == S_ACCUM) | new_frame);
    w_clr      = new_frame;
    w_clr_post = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (new_frame) w_state_n = S_ACCUM;
      end
      S_ACCUM: begin
        if (end_frame) begin
          w_state_n  = S_REPORT;
          w_rpt      = 1'b1;
          w_clr      = 1'b0;
          w_pend_n   = new_frame;
          w_clr_post = new_frame;
        end
      end
      S_REPORT: begin
        w_state_n = (new_frame | r_pend) ? S_ACCUM : S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    color_blob_ch #(
      .PIX_W(PIX_W), .POS_W(POS_W), .CNT_W(CNT_W), .MIN_PIX(MIN_PIX)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_pix     (w_pix),
      .i_clr     (w_clr),
      .i_rpt     (w_rpt),
      .i_clr_post(w_clr_post),
      .i_R       (i_R),
      .i_G       (i_G),
      .i_B       (i_B),
      .i_r_min   (i_r_min[c*PIX_W +: PIX_W]),
      .i_g_max   (i_g_max[c*PIX_W +: PIX_W]),
      .i_b_max   (i_b_max[c*PIX_W +: PIX_W]),
      .i_X_pos   (i_X_pos),
      .i_Y_pos   (i_Y_pos),
      .o_detect  (o_detect[c]),
      .o_first_x (o_first_x[c*POS_W +: POS_W]),
      .o_first_y (o_first_y[c*POS_W +: POS_W]),
      .o_x_min   (o_x_min[c*POS_W +: POS_W]),
      .o_x_max   (o_x_max[c*POS_W +: POS_W]),
      .o_y_min   (o_y_min[c*POS_W +: POS_W]),
      .o_y_max   (o_y_max[c*POS_W +: POS_W]),
      .o_count   (o_count[c*CNT_W +: CNT_W]),
      .o_found   (o_found[c])
    );
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// tb_color_blob_tracker: directed frames with hand-computed reports.
// Two instances share the stimulus; u_sat has a 3-bit counter.
module tb_color_blob_tracker;
  localparam int PIX_W = 10, POS_W = 13, NUM_CH = 2, CNT_W = 20, SCW = 3;

  logic clk = 1'b0;
  logic rst, i_valid, new_frame, end_frame;
  logic [PIX_W-1:0] i_R, i_G, i_B;
  logic [POS_W-1:0] i_X_pos, i_Y_pos;
  logic [NUM_CH*PIX_W-1:0] i_r_min, i_g_max, i_b_max;

  logic [NUM_CH-1:0]       o_detect, o_found, s_detect, s_found;
  logic [NUM_CH*POS_W-1:0] o_first_x, o_first_y, o_x_min, o_x_max, o_y_min, o_y_max;
  logic [NUM_CH*POS_W-1:0] s_first_x, s_first_y, s_x_min, s_x_max, s_y_min, s_y_max;
  logic [NUM_CH*CNT_W-1:0] o_count;
  logic [NUM_CH*SCW-1:0]   s_count;
  logic o_frame_done, s_frame_done;

  int n_chk = 0, n_err = 0, n_done = 0, d0;

  always #5 clk = ~clk;

  color_blob_tracker #(.PIX_W(PIX_W), .POS_W(POS_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIN_PIX(16)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_R(i_R), .i_G(i_G), .i_B(i_B),
    .i_X_pos(i_X_pos), .i_Y_pos(i_Y_pos), .new_frame(new_frame), .end_frame(end_frame),
    .i_r_min(i_r_min), .i_g_max(i_g_max), .i_b_max(i_b_max), .o_detect(o_detect),
    .o_first_x(o_first_x), .o_first_y(o_first_y), .o_x_min(o_x_min), .o_x_max(o_x_max),
    .o_y_min(o_y_min), .o_y_max(o_y_max), .o_count(o_count), .o_found(o_found),
    .o_frame_done(o_frame_done));

  color_blob_tracker #(.PIX_W(PIX_W), .POS_W(POS_W), .NUM_CH(NUM_CH), .CNT_W(SCW), .MIN_PIX(16)) u_sat (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_R(i_R), .i_G(i_G), .i_B(i_B),
    .i_X_pos(i_X_pos), .i_Y_pos(i_Y_pos), .new_frame(new_frame), .end_frame(end_frame),
    .i_r_min(i_r_min), .i_g_max(i_g_max), .i_b_max(i_b_max), .o_detect(s_detect),
    .o_first_x(s_first_x), .o_first_y(s_first_y), .o_x_min(s_x_min), .o_x_max(s_x_max),
    .o_y_min(s_y_min), .o_y_max(s_y_max), .o_count(s_count), .o_found(s_found),
    .o_frame_done(s_frame_done));

  // Count frame-done pulses away from the active edge.
  always @(negedge clk) if (o_frame_done) n_done <= n_done + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rep(input string t, input int c, input int fx, fy, x0, x1, y0, y1, n, f);
    chk({t, ".fx"},    64'(o_first_x[c*POS_W +: POS_W]), 64'(fx));
    chk({t, ".fy"},    64'(o_first_y[c*POS_W +: POS_W]), 64'(fy));
    chk({t, ".xmin"},  64'(o_x_min[c*POS_W +: POS_W]),   64'(x0));
    chk({t, ".xmax"},  64'(o_x_max[c*POS_W +: POS_W]),   64'(x1));
    chk({t, ".ymin"},  64'(o_y_min[c*POS_W +: POS_W]),   64'(y0));
    chk({t, ".ymax"},  64'(o_y_max[c*POS_W +: POS_W]),   64'(y1));
    chk({t, ".count"}, 64'(o_count[c*CNT_W +: CNT_W]),   64'(n));
    chk({t, ".found"}, 64'(o_found[c]),                  64'(f));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic nf, ef, v, input int r, g, b, x, y);
    new_frame = nf; end_frame = ef; i_valid = v;
    i_R = PIX_W'(r); i_G = PIX_W'(g); i_B = PIX_W'(b);
    i_X_pos = POS_W'(x); i_Y_pos = POS_W'(y);
    tick();
    new_frame = 1'b0; end_frame = 1'b0; i_valid = 1'b0;
  endtask

  task automatic hit(input int x, y);
    drv(1'b0, 1'b0, 1'b1, 600, 100, 100, x, y);
  endtask

  initial begin
    rst = 1'b0; i_valid = 1'b0; new_frame = 1'b0; end_frame = 1'b0;
    i_R = '0; i_G = '0; i_B = '0; i_X_pos = '0; i_Y_pos = '0;
    // ch0: R>511 G<192 B<192 ; ch1: R>100 only
    i_r_min = {10'd100, 10'd511};
    i_g_max = {10'd1023, 10'd192};
    i_b_max = {10'd1023, 10'd192};
    tick(); tick();
    chk("rst.done",  64'(o_frame_done), 64'(0));
    chk("rst.count", 64'(o_count), 64'(0));
    chk("rst.xmin",  64'(o_x_min), 64'(0));
    chk("rst.det",   64'(o_detect), 64'(0));
    rst = 1'b1; tick();

    // Basic frame: three red hits plus a pixel only ch1 accepts.
    drv(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    hit(10, 5);  chk("t1.det0", 64'(o_detect), 64'(3));
    hit(20, 7);  chk("t1.det1", 64'(o_detect), 64'(0));
    hit(15, 9);
    drv(1'b0, 1'b0, 1'b1, 300, 100, 100, 3, 30);
    chk("t1.det2", 64'(o_detect), 64'(0));
    chk("t1.nodone", 64'(o_frame_done), 64'(0));
    drv(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    chk("t1.done", 64'(o_frame_done), 64'(1));
    chk_rep("t1.c0", 0, 10, 5, 10, 20, 5, 9, 3, 0);
    chk_rep("t1.c1", 1, 10, 5, 3, 20, 5, 30, 4, 0);
    chk("t1.sat", 64'(s_count[0 +: SCW]), 64'(3));
    tick();
    chk("t1.done_off", 64'(o_frame_done), 64'(0));

    // 16 hits, first on new_frame cycle, last on end_frame cycle.
    drv(1'b1, 1'b0, 1'b1, 600, 100, 100, 100, 50);
    for (int i = 0; i < 14; i++) hit(110 + i, 55);
    drv(1'b0, 1'b1, 1'b1, 600, 100, 100, 200, 60);
    chk_rep("t2.c0", 0, 100, 50, 100, 200, 50, 60, 16, 1);
    chk("t2.sat", 64'(s_count[0 +: SCW]), 64'(7));
    tick();

    // Strict-compare boundaries, then 15 hits.
    drv(1'b1, 1'b0, 1'b1, 511, 100, 100, 1, 1);
    chk("t3.det", 64'(o_detect), 64'(2));
    drv(1'b0, 1'b0, 1'b1, 600, 192, 100, 2, 2);
    drv(1'b0, 1'b0, 1'b1, 600, 100, 192, 3, 3);
    for (int i = 0; i < 15; i++) hit(40 + i, 40);
    drv(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    chk_rep("t3.c0", 0, 40, 40, 40, 54, 40, 40, 15, 0);
    chk_rep("t3.c1", 1, 1, 1, 1, 54, 1, 40, 18, 1);
    chk("t3.sat", 64'(s_count[0 +: SCW]), 64'(7));
    tick();

    // Abort mid-frame with new_frame.
    d0 = n_done;
    drv(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) hit(60 + i, 2);
    drv(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    chk("t4.nodone", 64'(o_frame_done), 64'(0));
    hit(70, 3);  chk("t4.det", 64'(o_detect[0]), 64'(1));
    hit(71, 4);
    drv(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    chk_rep("t4.c0", 0, 70, 3, 70, 71, 3, 4, 2, 0);
    tick(); tick();
    chk("t4.ndone", 64'(n_done - d0), 64'(1));

    // new_frame + end_frame together: report 4, then restart from zero.
    drv(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    hit(80, 10); hit(81, 10); hit(82, 10);
    drv(1'b1, 1'b1, 1'b1, 600, 100, 100, 83, 11);
    chk("t5.done", 64'(o_frame_done), 64'(1));
    chk_rep("t5.c0", 0, 80, 10, 80, 83, 10, 11, 4, 0);
    tick();
    hit(90, 20); chk("t5.det", 64'(o_detect[0]), 64'(1));
    hit(91, 21);
    drv(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    chk_rep("t5.c0b", 0, 90, 20, 90, 91, 20, 21, 2, 0);
    tick();

    // Reset mid-frame: everything clears, no done pulse.
    drv(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    hit(5, 5); hit(6, 6); hit(7, 7);
    d0 = n_done;
    rst = 1'b0; tick();
    chk("t6.count", 64'(o_count), 64'(0));
    chk("t6.found", 64'(o_found), 64'(0));
    chk("t6.fx",    64'(o_first_x), 64'(0));
    chk("t6.done",  64'(o_frame_done), 64'(0));
    rst = 1'b1;
    drv(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("t6.ndone", 64'(n_done - d0), 64'(0));
    chk("t6.count2", 64'(o_count), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
